// File: rtl/sha256_w_if.sv
// Job handshake between a schedule producer, the W expander and the compression rounds.
// The slave side is the expander; the master side feeds windows in and drains results.
interface sha256_w_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] Win;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] W;
  logic         busy;

  modport master (
    output in_valid, Win, out_ready,
    input  in_ready, out_valid, W, busy
  );

  modport slave (
    input  in_valid, Win, out_ready,
    output in_ready, out_valid, W, busy
  );
endinterface

// File: rtl/sha256_w_expander.sv
// SHA-256 message-schedule expander: advances a 16-word window by STEPS steps,
// STEPS_PER_CYCLE per clock, and hands the result out through valid/ready.
module sha256_w_expander #(
  parameter int STEPS           = 16,
  parameter int STEPS_PER_CYCLE = 1,
  parameter int CNT_W           = 6
) (
  input  logic      clk,
  input  logic      reset,
  sha256_w_if.slave bus
);

  if (STEPS < 1 || STEPS > 48 ||
      !(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4) ||
      (STEPS % STEPS_PER_CYCLE) != 0 || STEPS >= (1 << CNT_W)) begin : g_bad_params
    $error("sha256_w_expander: illegal STEPS/STEPS_PER_CYCLE/CNT_W combination");
  end

  localparam logic [CNT_W-1:0] STEPS_C = CNT_W'(STEPS);
  localparam logic [CNT_W-1:0] SPC_C   = CNT_W'(STEPS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [511:0]       win_p1;
  logic [511:0]       step_p0;
  logic               in_ready;
  logic               out_valid;
  logic               busy;

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // One schedule step: compute W[t] from the window and slide the window down a word.
  function automatic logic [511:0] sched_step(input logic [511:0] w);
    logic [31:0] nw;
    nw = small_sigma1(w[14*32 +: 32]) + w[9*32 +: 32]
       + small_sigma0(w[1*32 +: 32]) + w[0 +: 32];
    return {nw, w[511:32]};
  endfunction

  // ---- stage p0: combinational unrolled steps from the registered window
  always_comb begin
    step_p0 = win_p1;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      step_p0 = sched_step(step_p0);
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt + SPC_C == STEPS_C) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p1: window register, counter and state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      win_p1 <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            win_p1 <= bus.Win;
            cnt    <= '0;
          end
        end
        RUN: begin
          win_p1 <= step_p0;
          cnt    <= cnt + SPC_C;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.W         = win_p1;

endmodule

// File: tb/tb_sha256_w_expander.sv
// Bench for sha256_w_expander: four parameterisations checked against a
// schedule-array reference model and the published test vectors.
module tb_sha256_w_expander;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [511:0] KV_IN  = 512'h15a907c030cc0782b3d2bacefd456cd2f5bd2eab3513260d2cd900fc00000000000000008840290ac93b0c4ed1ca106527a51219f45dd1e9671d0e2f02000000;
  localparam logic [511:0] KV_OUT = 512'hcef23042773e4fe9d16ccc0f2759d27027a6cae51ddd458fb2ff0c9db3bfff3daf840f975dd99de0f9f4ecc2e8913345e57e7c442ac838a7f86712e5c3bcb098;

  always #5 clk = ~clk;

  sha256_w_if b1 ();
  sha256_w_if b4 ();
  sha256_w_if bs1 ();
  sha256_w_if bs2 ();

  sha256_w_expander #(.STEPS(16), .STEPS_PER_CYCLE(1), .CNT_W(6)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  sha256_w_expander #(.STEPS(16), .STEPS_PER_CYCLE(4), .CNT_W(6)) dut4 (.clk(clk), .reset(reset), .bus(b4));
  sha256_w_expander #(.STEPS(1),  .STEPS_PER_CYCLE(1), .CNT_W(6)) duts1 (.clk(clk), .reset(reset), .bus(bs1));
  sha256_w_expander #(.STEPS(2),  .STEPS_PER_CYCLE(1), .CNT_W(6)) duts2 (.clk(clk), .reset(reset), .bus(bs2));

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Classic schedule recurrence over a flat word array, then take the last 16 words.
  function automatic logic [511:0] model(input logic [511:0] win, input int steps);
    logic [31:0]  w [0:63];
    logic [511:0] r;
    for (int k = 0; k < 16; k++) w[k] = win[32*k +: 32];
    for (int t = 16; t < 16 + steps; t++) begin
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
    for (int k = 0; k < 16; k++) r[32*k +: 32] = w[steps + k];
    return r;
  endfunction

  function automatic logic [511:0] rand_win();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[32*k +: 32] = $urandom();
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    n_tests++; if (b1.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", b1.in_ready); end
    n_tests++; if (b1.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", b1.out_valid); end
    n_tests++; if (b1.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", b1.busy); end
    n_tests++; if (b1.W !== 512'h0) begin n_fail++; $display("FAIL rst_W got %h want 0", b1.W); end
    n_tests++;
    if ({b4.in_ready, b4.out_valid, b4.busy, bs1.in_ready, bs1.out_valid, bs1.busy,
         bs2.in_ready, bs2.out_valid, bs2.busy} !== 9'b100_100_100 ||
        (b4.W | bs1.W | bs2.W) !== 512'h0) begin
      n_fail++; $display("FAIL rst_other_duts got %b want 100100100",
        {b4.in_ready, b4.out_valid, b4.busy, bs1.in_ready, bs1.out_valid, bs1.busy,
         bs2.in_ready, bs2.out_valid, bs2.busy});
    end
  endtask

  // Accept one vector on both 16-step DUTs together and check latency and result.
  task automatic run_pair(input logic [511:0] v, input logic [511:0] exp_w, input string tag);
    int lat1, lat4;
    b1.Win = v; b4.Win = v;
    b1.in_valid = 1'b1; b4.in_valid = 1'b1;
    tick();
    b1.in_valid = 1'b0; b4.in_valid = 1'b0;
    n_tests++;
    if (b1.busy !== 1'b1 || b1.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s_run_flags busy=%b in_ready=%b want 1/0", tag, b1.busy, b1.in_ready);
    end
    lat1 = -1; lat4 = -1;
    for (int c = 1; c <= 40 && (lat1 < 0 || lat4 < 0); c++) begin
      tick();
      if (lat1 < 0 && b1.out_valid === 1'b1) lat1 = c;
      if (lat4 < 0 && b4.out_valid === 1'b1) lat4 = c;
    end
    n_tests++; if (lat1 != 16) begin n_fail++; $display("FAIL %s_lat_spc1 got %0d want 16", tag, lat1); end
    n_tests++; if (lat4 != 4) begin n_fail++; $display("FAIL %s_lat_spc4 got %0d want 4", tag, lat4); end
    n_tests++; if (b1.W !== exp_w) begin n_fail++; $display("FAIL %s_W_spc1 got %h want %h", tag, b1.W, exp_w); end
    n_tests++; if (b4.W !== exp_w) begin n_fail++; $display("FAIL %s_W_spc4 got %h want %h", tag, b4.W, exp_w); end
    b1.out_ready = 1'b1; b4.out_ready = 1'b1;
    tick();
    b1.out_ready = 1'b0; b4.out_ready = 1'b0;
    n_tests++;
    if (b1.out_valid !== 1'b0 || b4.out_valid !== 1'b0 || b1.in_ready !== 1'b1 || b4.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_release out_valid=%b%b in_ready=%b%b want 00/11", tag,
        b1.out_valid, b4.out_valid, b1.in_ready, b4.in_ready);
    end
  endtask

  task automatic test_known_vector();
    run_pair(KV_IN, KV_OUT, "kv");
  endtask

  task automatic test_random();
    logic [511:0] v;
    for (int i = 0; i < 6; i++) begin
      v = rand_win();
      run_pair(v, model(v, 16), "rand");
    end
  endtask

  task automatic test_word0();
    int l1, l2;
    bs1.Win = 512'h1; bs2.Win = 512'h1;
    bs1.in_valid = 1'b1; bs2.in_valid = 1'b1;
    tick();
    bs1.in_valid = 1'b0; bs2.in_valid = 1'b0;
    l1 = -1; l2 = -1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (l1 < 0 && bs1.out_valid === 1'b1) l1 = c;
      if (l2 < 0 && bs2.out_valid === 1'b1) l2 = c;
    end
    n_tests++; if (l1 != 1) begin n_fail++; $display("FAIL w0_lat_steps1 got %0d want 1", l1); end
    n_tests++; if (l2 != 2) begin n_fail++; $display("FAIL w0_lat_steps2 got %0d want 2", l2); end
    n_tests++; if (bs1.W !== (512'h1 << 480)) begin n_fail++; $display("FAIL w0_W_steps1 got %h want 1<<480", bs1.W); end
    n_tests++; if (bs2.W !== (512'h1 << 448)) begin n_fail++; $display("FAIL w0_W_steps2 got %h want 1<<448", bs2.W); end
    bs1.out_ready = 1'b1; bs2.out_ready = 1'b1;
    tick();
    bs1.out_ready = 1'b0; bs2.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [511:0] va, vb, ea, eb;
    int lat;
    va = rand_win(); vb = rand_win();
    ea = model(va, 16); eb = model(vb, 16);
    b1.Win = va; b1.in_valid = 1'b1;
    tick();
    b1.in_valid = 1'b0;
    lat = 0;
    while (b1.out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    n_tests++; if (lat != 16) begin n_fail++; $display("FAIL bp_lat_a got %0d want 16", lat); end
    b1.Win = vb; b1.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++;
      if (b1.out_valid !== 1'b1 || b1.W !== ea || b1.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold cyc %0d out_valid=%b in_ready=%b W=%h want 1/0 W=%h",
          c, b1.out_valid, b1.in_ready, b1.W, ea);
      end
    end
    b1.out_ready = 1'b1;
    tick();
    b1.out_ready = 1'b0;
    n_tests++;
    if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0 || b1.busy !== 1'b0 || b1.W !== ea) begin
      n_fail++; $display("FAIL bp_back_idle in_ready=%b out_valid=%b busy=%b W=%h want 1/0/0 W=%h",
        b1.in_ready, b1.out_valid, b1.busy, b1.W, ea);
    end
    tick();
    b1.in_valid = 1'b0;
    n_tests++; if (b1.W !== vb || b1.busy !== 1'b1) begin n_fail++; $display("FAIL bp_accept_b W=%h busy=%b want %h/1", b1.W, b1.busy, vb); end
    lat = 0;
    while (b1.out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    n_tests++; if (lat != 16 || b1.W !== eb) begin n_fail++; $display("FAIL bp_result_b lat=%0d W=%h want 16 W=%h", lat, b1.W, eb); end
    b1.out_ready = 1'b1;
    tick();
    b1.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    b1.Win = rand_win(); b1.in_valid = 1'b1;
    tick();
    b1.in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_tests++;
    if (b1.in_ready !== 1'b1 || b1.busy !== 1'b0 || b1.out_valid !== 1'b0 || b1.W !== 512'h0) begin
      n_fail++; $display("FAIL mid_reset in_ready=%b busy=%b out_valid=%b W=%h want 1/0/0/0",
        b1.in_ready, b1.busy, b1.out_valid, b1.W);
    end
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (b1.out_valid === 1'b1) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL mid_reset_no_out got %0d out_valid cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [511:0] va, vb;
    int acc[$];
    int ov[$];
    logic [511:0] ow[$];
    logic pre_rdy, pre_vld;
    va = rand_win(); vb = rand_win();
    b1.out_ready = 1'b1;
    b1.Win = va; b1.in_valid = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      pre_rdy = b1.in_ready; pre_vld = b1.in_valid;
      tick();
      if (pre_rdy && pre_vld) begin
        acc.push_back(c);
        if (acc.size() == 1) b1.Win = vb;
        else b1.in_valid = 1'b0;
      end
      if (b1.out_valid === 1'b1) begin ov.push_back(c); ow.push_back(b1.W); end
    end
    b1.out_ready = 1'b0;
    b1.in_valid = 1'b0;
    n_tests++; if (acc.size() != 2) begin n_fail++; $display("FAIL b2b_accepts got %0d want 2", acc.size()); end
    n_tests++; if (ov.size() != 2) begin n_fail++; $display("FAIL b2b_out_cycles got %0d want 2", ov.size()); end
    if (acc.size() == 2 && ov.size() == 2) begin
      n_tests++; if (acc[1] - acc[0] != 18) begin n_fail++; $display("FAIL b2b_period got %0d want 18", acc[1] - acc[0]); end
      n_tests++; if (ov[0] - acc[0] != 16) begin n_fail++; $display("FAIL b2b_lat_a got %0d want 16", ov[0] - acc[0]); end
      n_tests++; if (ow[0] !== model(va, 16)) begin n_fail++; $display("FAIL b2b_W_a got %h want %h", ow[0], model(va, 16)); end
      n_tests++; if (ow[1] !== model(vb, 16)) begin n_fail++; $display("FAIL b2b_W_b got %h want %h", ow[1], model(vb, 16)); end
    end
  endtask

  initial begin
    b1.in_valid = 1'b0;  b1.Win = '0;  b1.out_ready = 1'b0;
    b4.in_valid = 1'b0;  b4.Win = '0;  b4.out_ready = 1'b0;
    bs1.in_valid = 1'b0; bs1.Win = '0; bs1.out_ready = 1'b0;
    bs2.in_valid = 1'b0; bs2.Win = '0; bs2.out_ready = 1'b0;
    test_reset();
    test_known_vector();
    test_word0();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
